serial_bit_deser: RTL
=====================

# serial_bit_deser

Serial-to-parallel receiver that pairs with the team's bit-reversal datapath. It collects a one-bit-per-cycle stream into WIDTH-bit words and restores natural bit order whether the sender shifted LSB-first or MSB-first. Each completed word is presented on a one-entry valid/ready output buffer. It sits at the ingress of a serial link, upstream of any parallel word consumer.

## Interface
- WIDTH, 8, word width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear: bit counter, buffer, overrun
- sin_valid  input  1  sin_bit is sampled on this edge
- sin_bit  input  1  serial data bit
- lsb_first  input  1  bit order of the word being received (1 = LSB first)
- dout  output  WIDTH  assembled word, natural order (bit WIDTH-1 = MSB)
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when dout_valid=1
- overrun  output  1  sticky: a completed word was dropped
- bit_cnt  output  $clog2(WIDTH+1)  bits received in current word

## Operation
- Reset (async, rst=1): dout=0, dout_valid=0, overrun=0, bit_cnt=0, shift register=0, latched order=0.
- Receive: on each edge with sin_valid=1, sin_bit is shifted in and bit_cnt increments. Edges with sin_valid=0 hold all receive state.
- Order latch: lsb_first is sampled on the edge that takes the first bit (bit_cnt=0). The latched value governs the whole word; later changes take effect at the next word.
- Bit placement, LSB-first: the k-th received bit (k=0..WIDTH-1) lands in dout[k].
- Bit placement, MSB-first: the k-th received bit lands in dout[WIDTH-1-k].
- Word complete: occurs on the edge taking bit WIDTH-1. On that edge bit_cnt returns to 0, and the word is offered to the output buffer.
- Buffer load: the word loads when dout_valid=0, or when dout_valid=1 and dout_ready=1 on the same edge. On load, dout gets the word and dout_valid=1.
- Overrun: if dout_valid=1 and dout_ready=0 at word completion, the new word is discarded. dout is unchanged and overrun is set to 1. overrun stays 1 until clr or rst.
- Handshake: dout_valid clears on an edge with dout_valid=1, dout_ready=1 and no simultaneous load. dout is stable while dout_valid=1 and not consumed.
- Receive is independent of buffer state: bits keep shifting while a word waits.
- clr=1 (synchronous, overrides all other inputs that cycle): bit_cnt=0, dout_valid=0, overrun=0. dout retains its value. A bit presented on the same edge is discarded.
- Reset mid-word: the partial word is lost; reception restarts at bit 0.

## Timing
- Latency: dout/dout_valid update on the same edge that samples the last bit, so they are visible in the next cycle.
- Back-to-back words with sin_valid held high:
  - one word per WIDTH cycles;
  - no bubble is required between words;
  - a consumer holding dout_ready=1 never causes overrun.
- bit_cnt is registered and reflects bits received before the current edge.

## Configuration
- SERIAL_BIT_DESER_PARITY_EN defined:
  - each word is followed by one extra even-parity bit;
  - a word completes on the edge taking bit index WIDTH (the parity bit), and bit_cnt counts to WIDTH;
  - adds output parity_err (1 bit, reset 0), loaded with dout as (XOR of data bits XOR parity bit);
  - parity_err is meaningful while dout_valid=1;
  - a dropped (overrun) word does not update parity_err.
- Undefined: no parity bit; parity_err port absent; behaviour exactly as above.

## Test plan
- LSB-first order: rst, then bits 1,1,0,0,1,1,0,1 with lsb_first=1 and dout_ready=1 → dout=8'hB3, dout_valid=1 for one cycle after the 8th bit edge.
- MSB-first order: same bit sequence with lsb_first=0 → dout=8'hCD; also 8'hFF all ones → 8'hFF, and single leading 1 then seven 0s → 8'h80.
- Overrun: dout_ready=0, send 8'h01 then 8'h80 back-to-back LSB-first → dout stays 8'h01, overrun=1 after the 16th bit. Raising dout_ready clears dout_valid; overrun stays 1 until clr.
- Simultaneous consume and load: dout_ready=1 while holding 8'hAA, with 8'h55 completing on the same edge → dout=8'h55, dout_valid stays 1, overrun=0.
- Gaps and mid-word events: insert sin_valid=0 gaps inside a word → same result as without gaps. Assert rst after 4 bits → bit_cnt=0, and the next 8 bits form a clean word. Toggle lsb_first after bit 3 → no effect on the current word.
- Parity (with SERIAL_BIT_DESER_PARITY_EN): send 8'hB3 + parity 1 → parity_err=0; send 8'hB3 + parity 0 → parity_err=1.

Source files
------------

// File: rtl/serial_bit_deser.sv
// Serial-to-parallel receiver: assembles a 1-bit stream into WIDTH-bit words in natural order.
// Optional SERIAL_BIT_DESER_PARITY_EN appends an even-parity bit per word and adds parity_err.
module serial_bit_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         sin_valid,
    input  logic                         sin_bit,
    input  logic                         lsb_first,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         overrun,
`ifdef SERIAL_BIT_DESER_PARITY_EN
    output logic                         parity_err,
`endif
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SERIAL_BIT_DESER_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word_c;
    logic [CW-1:0]    idx_c;
    logic             order_q;
    logic             eff_lsb_c;
    logic             done_c;
    logic             load_c;
    logic             drop_c;

    // Place the incoming bit directly at its natural-order position; the
    // parity bit maps to an out-of-range index and leaves the word untouched.
    always_comb begin
        eff_lsb_c = (bit_cnt == '0) ? lsb_first : order_q;
        idx_c     = eff_lsb_c ? bit_cnt : (CW'(WIDTH - 1) - bit_cnt);
        word_c    = sreg;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sin_valid && (idx_c == CW'(i))) begin
                word_c[i] = sin_bit;
            end
        end
        done_c = sin_valid && (bit_cnt == CW'(LAST));
        load_c = done_c && (!dout_valid || dout_ready);
        drop_c = done_c && dout_valid && !dout_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg       <= '0;
            order_q    <= 1'b0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_BIT_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (clr) begin
            bit_cnt    <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sin_valid) begin
                sreg    <= word_c;
                bit_cnt <= done_c ? '0 : (bit_cnt + CW'(1));
                if (bit_cnt == '0) begin
                    order_q <= lsb_first;
                end
            end
            if (load_c) begin
                dout       <= word_c;
                dout_valid <= 1'b1;
`ifdef SERIAL_BIT_DESER_PARITY_EN
                parity_err <= (^sreg) ^ sin_bit;
`endif
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
